// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: FSM states,
// branch opcode fields and the 16 condition codes.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_STEP = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [10:0] OP_BR    = 11'h6B0;    // instr[31:21]
    localparam logic [5:0]  OP_B     = 6'b000101;  // instr[31:26]
    localparam logic [7:0]  OP_BCOND = 8'h54;      // instr[31:24]
    localparam logic [7:0]  OP_CBZ   = 8'hB4;
    localparam logic [7:0]  OP_CBNZ  = 8'hB5;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of a 4-bit branch condition against the
// ALU flags {V,C,N,Z}.
module cond_eval
    import pc_seq_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_v, w_c, w_n, w_z;

    assign w_v = i_flags[3];
    assign w_c = i_flags[2];
    assign w_n = i_flags[1];
    assign w_z = i_flags[0];

    always_comb begin
        // NOTE: default before the case so every path assigns o_pass and no latch is inferred.
        o_pass = 1'b1;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = !w_z;
            COND_HS: o_pass = w_c;
            COND_LO: o_pass = !w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = !w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = !w_v;
            COND_HI: o_pass = w_c && !w_z;
            COND_LS: o_pass = !(w_c && !w_z);
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = !w_z && (w_n == w_v);
            COND_LE: o_pass = !(!w_z && (w_n == w_v));
            COND_AL: o_pass = 1'b1;
            COND_NV: o_pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: branch decode, free-run / stall / single-step
// control and a terminal halt state for the single-cycle datapath.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W   = 7,
    parameter int              DATA_W = 32,
    parameter int              CNT_W  = 16,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic [3:0]        flags,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              stall,
    input  logic              step_mode,
    input  logic              step_req,
    output logic [PC_W-1:0]   pc,
    output logic              branch_taken,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    state_t            r_state, w_state_nxt;
    logic [PC_W-1:0]   r_pc, w_next_pc;
    logic [CNT_W-1:0]  r_retired;
    logic              r_branch_taken, r_halted, r_step_prev;
    logic              w_halt_cond, w_step_edge, w_advance, w_taken, w_cond_pass;
    logic [31:0]       w_off26, w_off19;
    logic              w_unused;

    assign w_halt_cond = (instr == 32'h0) | (r_pc == {PC_W{1'b1}});
    assign w_step_edge = step_req & ~r_step_prev;

    // Offsets are word counts; only the low PC_W bits matter since PC math wraps.
    assign w_off26  = {{6{instr[25]}}, instr[25:0]};
    assign w_off19  = {{13{instr[23]}}, instr[23:5]};
    assign w_unused = ^{w_off26[31:PC_W], w_off19[31:PC_W]};

    cond_eval u_cond_eval (
        .i_cond  (instr[3:0]),
        .i_flags (flags),
        .o_pass  (w_cond_pass)
    );

    always_comb begin
        w_taken   = 1'b0;
        w_next_pc = r_pc + PC_W'(1);
        if (instr[31:21] == OP_BR) begin
            w_taken   = 1'b1;
            w_next_pc = reg_data[PC_W-1:0];
        end else if (instr[31:26] == OP_B) begin
            w_taken   = 1'b1;
            w_next_pc = r_pc + w_off26[PC_W-1:0];
        end else begin
            case (instr[31:24])
                OP_BCOND: w_taken = w_cond_pass;
                OP_CBZ:   w_taken = (reg_data == '0);
                OP_CBNZ:  w_taken = (reg_data != '0);
                default:  w_taken = 1'b0;
            endcase
            if (w_taken) begin
                w_next_pc = r_pc + w_off19[PC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    // halt_cond outranks mode changes; a mode change outranks a pending step edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_halt_cond)    w_state_nxt = ST_HALT;
                else if (step_mode) w_state_nxt = ST_STEP;
            end
            ST_STEP: begin
                if (w_halt_cond)     w_state_nxt = ST_HALT;
                else if (!step_mode) w_state_nxt = ST_RUN;
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_advance = 1'b0;
        case (r_state)
            ST_RUN:  w_advance = !w_halt_cond && !step_mode && !stall;
            ST_STEP: w_advance = !w_halt_cond && step_mode && w_step_edge;
            default: w_advance = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc           <= RST_PC;
            r_retired      <= '0;
            r_branch_taken <= 1'b0;
            r_halted       <= 1'b0;
            r_step_prev    <= 1'b0;
        end else begin
            r_step_prev    <= step_req;
            r_halted       <= (w_state_nxt == ST_HALT);
            r_branch_taken <= w_advance & w_taken;
            if (w_advance) begin
                r_pc <= w_next_pc;
                if (r_retired != {CNT_W{1'b1}}) begin
                    r_retired <= r_retired + CNT_W'(1);
                end
            end
        end
    end

    assign pc           = r_pc;
    assign retired      = r_retired;
    assign branch_taken = r_branch_taken;
    assign halted       = r_halted;

endmodule
